word_wide_inv_add_round_keys: RTL

- Decryption-side counterpart of the encryption AddRoundKey stage.
- XORs each 128-bit state beat with the matching round key taken from the 1408-bit expanded key schedule.
- Round keys are applied in reverse order, round 10 down to round 0. A separate round counter is kept for each of the four interleaved pointer streams.
- Sits in the inverse-cipher pipeline, between InvShiftRows/InvSubBytes and InvMixColumns. Uses the same pointer-tagged valid protocol as the encryption pipeline.

---
 rtl/word_wide_inv_add_round_keys.sv | 85 ++++++++
 1 files changed

// File: rtl/word_wide_inv_add_round_keys.sv
// Inverse-cipher AddRoundKey: XORs each state beat with a round key,
// walking keys 10 down to 0 independently for four pointer streams.
module word_wide_inv_add_round_keys #(
  parameter int DATA_W     = 128,
  parameter int NUM_ROUNDS = 10,
  parameter int CNT_W      = 4,
  parameter int CPU_W      = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_W-1:0]                data_in,
  input  logic                             data_in_vld,
  input  logic [1:0]                       pntr_num_in,
  input  logic [(NUM_ROUNDS+1)*DATA_W-1:0] key_schedule,
  input  logic                             cpu_rd,
  output logic [DATA_W-1:0]                data_out,
  output logic                             data_out_vld,
  output logic [1:0]                       pntr_num_out,
  output logic                             last_round_out,
  output logic [CPU_W-1:0]                 cpu_rd_data
);

  localparam int KS_W = (NUM_ROUNDS + 1) * DATA_W;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(NUM_ROUNDS);

  logic [CNT_W-1:0]  cnt [4];
  logic [CNT_W-1:0]  r;
  logic [DATA_W-1:0] rk;
  logic              is_last;
  logic              dbg;

  assign r       = cnt[pntr_num_in];
  assign is_last = (r == '0) || (r > RELOAD);

  // Round key select; out-of-range counts fall back to key 0.
  always_comb begin
    rk = key_schedule[KS_W-1 -: DATA_W];
    for (int i = 1; i <= NUM_ROUNDS; i++) begin
      if (r == CNT_W'(i))
        rk = key_schedule[KS_W-1-i*DATA_W -: DATA_W];
    end
  end

  // Datapath register: XOR result, tag and last flag held when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out       <= '0;
      data_out_vld   <= 1'b0;
      pntr_num_out   <= '0;
      last_round_out <= 1'b0;
    end else begin
      data_out_vld <= data_in_vld;
      if (data_in_vld) begin
        data_out       <= data_in ^ rk;
        pntr_num_out   <= pntr_num_in;
        last_round_out <= is_last;
      end
    end
  end

  // Per-pointer round counters: decrement, reloading after key 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++)
        cnt[i] <= RELOAD;
    end else if (data_in_vld) begin
      cnt[pntr_num_in] <= is_last ? RELOAD : r - 1'b1;
    end
  end

  // Sticky debug flag and CPU snapshot of pre-update counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbg         <= 1'b0;
      cpu_rd_data <= '0;
    end else begin
      if (cpu_rd && data_in_vld)
        dbg <= 1'b1;
      if (cpu_rd)
        cpu_rd_data <= {{15{1'b0}}, dbg,
                        cnt[3], cnt[2], cnt[1], cnt[0]};
    end
  end

endmodule
